sram_req_arbiter: RTL and testbench

Two-to-one arbiter that shares the core's single SRAM-like memory port between the instruction-fetch requester (port 0) and the EX-stage data requester (port 1). It sits between the pipeline and the SRAM-to-AXI bridge. It selects one request per cycle and holds that selection while the slave stalls. It tracks outstanding accepted transactions in an in-order owner FIFO, so each `data_ok`/`rdata` return is steered to the master that issued it.

---
 rtl/sram_req_arbiter_if.sv | 46 ++++
 rtl/sram_req_arbiter.sv | 118 +++++++++++
 tb/tb_sram_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_if.sv
// Bus bundle between the two pipeline requesters, the arbiter and the
// SRAM-like slave port.
//
// Handshake: a request is presented by holding req high with its fields
// stable; it is taken in the cycle where req and addr_ok are both high.
// Responses come back in issue order as one-cycle data_ok pulses, and rdata
// is valid only in those cycles. Once req is high and addr_ok is still low, the
// requester keeps the fields unchanged. It may drop req to cancel the request.
interface sram_req_arbiter_if;
    // Master side: bit/slice 0 = instruction fetch, bit/slice 1 = EX data
    logic [1:0]  m_req;
    logic [1:0]  m_wr;
    logic [3:0]  m_size;
    logic [63:0] m_addr;
    logic [7:0]  m_wstrb;
    logic [63:0] m_wdata;
    logic [1:0]  m_addr_ok;
    logic [1:0]  m_data_ok;
    logic [63:0] m_rdata;
    // Slave side: one shared memory port
    logic        s_req;
    logic        s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr;
    logic [3:0]  s_wstrb;
    logic [31:0] s_wdata;
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [31:0] s_rdata;

    // The arbiter serves the pipeline masters, so it takes the slave view.
    modport slave (
        input  m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        output s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
        input  s_addr_ok, s_data_ok, s_rdata
    );

    // The environment (pipeline masters plus memory) takes the master view.
    modport master (
        output m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        input  s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
        output s_addr_ok, s_data_ok, s_rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-like port arbiter. Data (port 1) has priority over inst
// (port 0). A grant is held while the slave stalls. An in-order owner FIFO
// steers each response back to the master that issued the request.
module sram_req_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    sram_req_arbiter_if.slave        bus,
    output logic                     dbg_lock_o,
    output logic                     dbg_lock_id_o,
    output logic [$clog2(DEPTH):0]   dbg_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {ST_FREE = 1'b0, ST_LOCKED = 1'b1} lock_state_e;

    lock_state_e   state_q, state_d;
    logic          lock_id_q, lock_id_d;
    logic          fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic lock_hit;
    logic grant;
    logic gnt_valid;
    logic full;
    logic s_req;
    logic accept;
    logic pop;
    logic head;
    logic sel;

    // Grant: a stalled request keeps the port only while its master still asks.
    // Otherwise data wins over inst.
    always_comb begin
        lock_hit  = (state_q == ST_LOCKED) && bus.m_req[lock_id_q];
        gnt_valid = |bus.m_req;
        grant     = 1'b1;
        if (lock_hit)
            grant = lock_id_q;
        else if (bus.m_req[1])
            grant = 1'b1;
        else if (bus.m_req[0])
            grant = 1'b0;
    end

    // Slave request, field mux (parks on port 1 when idle) and handshakes.
    always_comb begin
        full   = (count_q == FULL_CNT);
        s_req  = gnt_valid & ~full;
        accept = s_req & bus.s_addr_ok;
        sel    = s_req ? grant : 1'b1;
        head   = fifo_q[rd_ptr_q];
        pop    = bus.s_data_ok & (count_q != '0);

        bus.s_req   = s_req;
        bus.s_wr    = sel ? bus.m_wr[1]          : bus.m_wr[0];
        bus.s_size  = sel ? bus.m_size[3:2]      : bus.m_size[1:0];
        bus.s_addr  = sel ? bus.m_addr[63:32]    : bus.m_addr[31:0];
        bus.s_wstrb = sel ? bus.m_wstrb[7:4]     : bus.m_wstrb[3:0];
        bus.s_wdata = sel ? bus.m_wdata[63:32]   : bus.m_wdata[31:0];

        bus.m_addr_ok = accept ? {grant, ~grant} : 2'b00;
        bus.m_data_ok = pop    ? {head, ~head}   : 2'b00;
        bus.m_rdata   = {bus.s_rdata, bus.s_rdata};
    end

    // Lock FSM next state: lock on a stall, release on accept or withdraw.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        if (s_req && !bus.s_addr_ok) begin
            state_d   = ST_LOCKED;
            lock_id_d = grant;
        end else if (accept) begin
            state_d = ST_FREE;
        end else if ((state_q == ST_LOCKED) && !bus.m_req[lock_id_q]) begin
            state_d = ST_FREE;
        end
    end

    // Owner FIFO bookkeeping: push on accept, pop on a steered response.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(accept);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW+1)'(accept) - (PW+1)'(pop);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FREE;
            lock_id_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Owner FIFO storage: record which master owns each accepted transaction.
    always_ff @(posedge clk) begin
        if (accept)
            fifo_q[wr_ptr_q] <= grant;
    end

    assign dbg_lock_o    = (state_q == ST_LOCKED);
    assign dbg_lock_id_o = lock_id_q;
    assign dbg_count_o   = count_q;
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios followed by random traffic.
// Every cycle is compared against a transaction-level reference model.
module tb_sram_req_arbiter;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_req_arbiter_if bus ();
    logic       dbg_lock;
    logic       dbg_lock_id;
    logic [2:0] dbg_count;

    sram_req_arbiter #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .dbg_lock_o    (dbg_lock),
        .dbg_lock_id_o (dbg_lock_id),
        .dbg_count_o   (dbg_count)
    );

    // ---------------- scoreboard state ----------------
    logic [0:0] exp_q[$];     // owners of accepted, not yet answered transactions
    logic       held_v;       // a request was shown to the slave and left waiting
    logic       held_id;      // which master that waiting request belongs to
    logic [1:0] last_aok;     // masters accepted in the last sampled cycle
    int         n_vec;
    int         n_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
        bus.m_wr[i]             = wr;
        bus.m_size[i*2 +: 2]    = sz;
        bus.m_addr[i*32 +: 32]  = a;
        bus.m_wstrb[i*4 +: 4]   = st;
        bus.m_wdata[i*32 +: 32] = wd;
    endtask

    // Sample mid-cycle and compare every output against the reference model.
    // Model: the shared port serves whoever was left waiting if it still asks,
    // otherwise data before inst; at most DEPTH transactions may be in flight,
    // and responses return to owners in acceptance order.
    task automatic sample();
        logic [1:0] req;
        logic       g;
        logic       full;
        logic       esreq;
        logic       eacc;
        logic       pop;
        logic [1:0] eaok;
        logic [1:0] edok;
        int         si;
        @(negedge clk);
        req = bus.m_req;
        if (reset) begin
            check_eq("rst_s_req", bus.s_req, 1'b0);
            check_eq("rst_m_addr_ok", bus.m_addr_ok, 2'b00);
            check_eq("rst_m_data_ok", bus.m_data_ok, 2'b00);
            exp_q.delete();
            held_v   = 1'b0;
            held_id  = 1'b0;
            last_aok = 2'b00;
            return;
        end
        if (held_v && req[held_id]) g = held_id;
        else if (req[1])            g = 1'b1;
        else if (req[0])            g = 1'b0;
        else                        g = 1'b1;
        full  = (exp_q.size() == DEPTH);
        esreq = (req != 2'b00) && !full;
        eacc  = esreq && bus.s_addr_ok;
        eaok  = eacc ? (g ? 2'b10 : 2'b01) : 2'b00;
        pop   = bus.s_data_ok && (exp_q.size() != 0);
        edok  = 2'b00;
        if (pop) edok = exp_q[0][0] ? 2'b10 : 2'b01;
        si    = (esreq && !g) ? 0 : 1;

        check_eq("s_req", bus.s_req, esreq);
        check_eq("m_addr_ok", bus.m_addr_ok, eaok);
        check_eq("m_data_ok", bus.m_data_ok, edok);
        check_eq("m_rdata", bus.m_rdata, {bus.s_rdata, bus.s_rdata});
        check_eq("s_addr", bus.s_addr, bus.m_addr[si*32 +: 32]);
        check_eq("s_wr", bus.s_wr, bus.m_wr[si]);
        check_eq("s_size", bus.s_size, bus.m_size[si*2 +: 2]);
        check_eq("s_wstrb", bus.s_wstrb, bus.m_wstrb[si*4 +: 4]);
        check_eq("s_wdata", bus.s_wdata, bus.m_wdata[si*32 +: 32]);
        check_eq("outstanding", dbg_count, exp_q.size());
        check_eq("lock", dbg_lock, held_v);

        if (pop) void'(exp_q.pop_front());
        if (eacc) exp_q.push_back(g);
        if (esreq && !bus.s_addr_ok) begin
            held_v  = 1'b1;
            held_id = g;
        end else if (eacc || (held_v && !req[held_id])) begin
            held_v = 1'b0;
        end
        last_aok = eaok;
    endtask

    // Random traffic: pending requests hold their fields (occasionally cancel),
    // idle masters may start new requests, memory answers randomly.
    task automatic rand_drive();
        tick();
        bus.s_addr_ok = ($urandom_range(0, 3) != 0);
        bus.s_rdata   = $urandom;
        if ($urandom_range(0, 149) == 0) begin
            reset         = 1'b1;
            bus.m_req     = 2'b00;
            bus.s_data_ok = 1'b0;
            return;
        end
        reset         = 1'b0;
        bus.s_data_ok = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < 2; i++) begin
            if (bus.m_req[i] && !last_aok[i]) begin
                if ($urandom_range(0, 15) == 0) bus.m_req[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                bus.m_req[i] = 1'b1;
                set_m(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                      $urandom, 4'($urandom_range(0, 15)), $urandom);
            end else begin
                bus.m_req[i] = 1'b0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;  n_err = 0;
        held_v = 1'b0;  held_id = 1'b0;  last_aok = 2'b00;
        reset = 1'b1;
        bus.m_req = '0;  bus.m_wr = '0;  bus.m_size = '0;  bus.m_addr = '0;
        bus.m_wstrb = '0;  bus.m_wdata = '0;
        bus.s_addr_ok = 1'b0;  bus.s_data_ok = 1'b0;  bus.s_rdata = '0;

        // Reset and idle, stray response ignored
        repeat (2) begin sample(); tick(); end
        reset = 1'b0;
        bus.s_data_ok = 1'b1;  bus.s_rdata = 32'hDEADBEEF;
        sample();
        check_eq("idle_data_ok", bus.m_data_ok, 2'b00);
        check_eq("idle_s_req", bus.s_req, 1'b0);
        tick();
        bus.s_data_ok = 1'b0;

        // Priority and return order
        set_m(0, 1'b0, 2'd2, 32'h1c000000, 4'hf, 32'h0);
        set_m(1, 1'b1, 2'd2, 32'h00001000, 4'hf, 32'hCAFE0001);
        bus.m_req = 2'b11;  bus.s_addr_ok = 1'b1;
        sample();
        check_eq("prio_c0_addr", bus.s_addr, 32'h00001000);
        check_eq("prio_c0_aok", bus.m_addr_ok, 2'b10);
        tick();
        bus.m_req = 2'b01;
        sample();
        check_eq("prio_c1_addr", bus.s_addr, 32'h1c000000);
        check_eq("prio_c1_aok", bus.m_addr_ok, 2'b01);
        tick();
        bus.m_req = 2'b00;  bus.s_addr_ok = 1'b0;
        sample(); tick();
        bus.s_data_ok = 1'b1;  bus.s_rdata = 32'h11111111;
        sample();
        check_eq("order_c3_dok", bus.m_data_ok, 2'b10);
        check_eq("order_c3_rdata", bus.m_rdata[63:32], 32'h11111111);
        tick();
        bus.s_rdata = 32'h22222222;
        sample();
        check_eq("order_c4_dok", bus.m_data_ok, 2'b01);
        tick();
        bus.s_data_ok = 1'b0;

        // Lock holds inst while the slave stalls, even after data asks
        set_m(0, 1'b0, 2'd2, 32'h1c000100, 4'hf, 32'h0);
        set_m(1, 1'b0, 2'd2, 32'h00002000, 4'hf, 32'h0);
        bus.m_req = 2'b01;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) bus.m_req = 2'b11;
            if (c == 3) bus.s_addr_ok = 1'b1;
            sample();
            check_eq("lock_addr", bus.s_addr, 32'h1c000100);
            if (c == 3) check_eq("lock_c3_aok", bus.m_addr_ok, 2'b01);
            tick();
        end
        bus.m_req = 2'b10;
        sample();
        check_eq("lock_c4_aok", bus.m_addr_ok, 2'b10);
        tick();
        bus.m_req = 2'b00;  bus.s_addr_ok = 1'b0;  bus.s_data_ok = 1'b1;
        repeat (2) begin sample(); tick(); end
        bus.s_data_ok = 1'b0;

        // Withdraw releases a data lock; inst is served next
        bus.m_req = 2'b10;
        sample(); tick();
        bus.m_req = 2'b01;  bus.s_addr_ok = 1'b1;
        sample();
        check_eq("withdraw_aok", bus.m_addr_ok, 2'b01);
        tick();
        bus.m_req = 2'b00;  bus.s_addr_ok = 1'b0;  bus.s_data_ok = 1'b1;
        sample(); tick();
        bus.s_data_ok = 1'b0;

        // Full: four accepts, fifth waits through the pop cycle
        bus.m_req = 2'b01;  bus.s_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_m(0, 1'b0, 2'd2, 32'h1c000200 + 32'(k * 4), 4'hf, 32'h0);
            sample(); tick();
        end
        set_m(0, 1'b0, 2'd2, 32'h1c000300, 4'hf, 32'h0);
        sample();
        check_eq("full_s_req", bus.s_req, 1'b0);
        tick();
        bus.s_data_ok = 1'b1;
        sample();
        check_eq("full_pop_s_req", bus.s_req, 1'b0);
        check_eq("full_pop_dok", bus.m_data_ok, 2'b01);
        tick();
        bus.s_data_ok = 1'b0;
        sample();
        check_eq("full_after_aok", bus.m_addr_ok, 2'b01);
        tick();

        // Drain to two, then push and pop together
        bus.m_req = 2'b00;  bus.s_data_ok = 1'b1;
        repeat (2) begin sample(); tick(); end
        bus.m_req = 2'b10;
        sample(); tick();
        bus.m_req = 2'b00;  bus.s_data_ok = 1'b0;
        sample();
        check_eq("pushpop_count", dbg_count, 3'd2);
        tick();

        // Reset with three outstanding, late response ignored
        bus.m_req = 2'b01;
        sample(); tick();
        reset = 1'b1;  bus.m_req = 2'b00;
        sample(); tick();
        reset = 1'b0;  bus.s_data_ok = 1'b1;
        sample();
        check_eq("post_reset_dok", bus.m_data_ok, 2'b00);
        tick();
        bus.s_data_ok = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sample();
            rand_drive();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
